// File: rtl/wb_regfile.sv
// Architectural register file: 32 x XLEN registers, two combinational read ports
// with write-back bypass, and a per-register in-flight write scoreboard.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_we,
    input  logic [4:0]      iss_rd,
    output logic            iss_full,
    input  logic            flush
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]  regs_q [32];
    logic [CNT_W-1:0] cnt_q  [32];
    logic [CNT_W-1:0] cnt_d  [32];

    // Entry 0 is held at zero so x0 reads as untracked without special-casing lookups.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i == 0 || flush) begin
                cnt_d[i] = '0;
            end else begin
                if ((iss_we && iss_rd == 5'(i) && cnt_q[i] != CNT_MAX) &&
                    !(wb_we && wb_rd == 5'(i) && cnt_q[i] != '0)) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else if (!(iss_we && iss_rd == 5'(i) && cnt_q[i] != CNT_MAX) &&
                             (wb_we && wb_rd == 5'(i) && cnt_q[i] != '0)) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (i != 0 && wb_we && wb_rd == 5'(i)) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    logic [1:0][4:0]      rd_addr;
    logic [1:0][XLEN-1:0] rd_data;
    logic [1:0]           rd_busy;

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // A pending write that is being written back this cycle is served by bypass, not a stall.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic             hit_w;
        logic [CNT_W-1:0] cnt_w;

        assign hit_w = wb_we && (wb_rd == rd_addr[gi]) && (rd_addr[gi] != 5'd0);
        assign cnt_w = cnt_q[rd_addr[gi]];

        assign rd_data[gi] = (rst || rd_addr[gi] == 5'd0) ? '0 :
                             hit_w ? wb_data : regs_q[rd_addr[gi]];
        assign rd_busy[gi] = (rd_addr[gi] != 5'd0) &&
                             ((cnt_w > CNT_ONE) || (cnt_w == CNT_ONE && !hit_w));
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign rs1_busy = rd_busy[0];
    assign rs2_busy = rd_busy[1];
    assign iss_full = (iss_rd != 5'd0) && (cnt_q[iss_rd] == CNT_MAX);

endmodule
